serial_sub_unit: RTL and testbench



---
 rtl/serial_sub_unit.sv | 105 ++++++++++
 tb/tb_serial_sub_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: A - B one bit per cycle, LSB first, through a single
// full-subtractor cell with a registered borrow feeding back into the next bit.
module serial_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;

  // Full-subtractor cell; the new result bit enters the top of the result shifter.
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_nxt  = {d, res[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // NOTE: every register here, including the operand and result shifters, is
  // cleared by reset and updated only with non-blocking assignments, so an
  // aborted operation leaves no stale state and never produces a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          br  <= br_nxt;
          res <= res_nxt;
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (last_bit) begin
            // d is the sign bit of the result on this final edge.
            diff       <= res_nxt;
            borrow_out <= br_nxt;
            ovf        <= (a_msb ^ b_msb) & (d ^ a_msb);
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Self-checking bench for serial_sub_unit (WIDTH = 8): directed corner cases,
// start-while-busy, asynchronous abort, back-to-back starts and random operands.
module tb_serial_sub_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] ta;
  logic [W-1:0] tb;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (ta),
    .b          (tb),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain modular / signed arithmetic.
  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return r[W-1:0];
  endfunction

  function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    s = int'($signed(x)) - int'($signed(y));
    return (s > 127) || (s < -128);
  endfunction

  // Drives one operation and returns what was observed; no comparisons here.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic busy0, output int lat,
                        output logic [W-1:0] od, output logic obo, output logic oov,
                        output logic busy_at_done, output logic done_after);
    @(negedge clk);
    ta = x; tb = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ta = W'($urandom); tb = W'($urandom);
    busy0 = busy;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      ta = W'($urandom); tb = W'($urandom);
      lat++;
    end
    od = diff; obo = borrow_out; oov = ovf; busy_at_done = busy;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ta = '0; tb = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, diff, borrow_out, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, ovf);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [5] = '{8'h35, 8'h00, 8'h80, 8'h10, 8'h7F};
    logic [W-1:0] vb [5] = '{8'h12, 8'h01, 8'h01, 8'h10, 8'hFF};
    logic [W-1:0] ed [5] = '{8'h23, 8'hFF, 8'h7F, 8'h00, 8'h80};
    logic         eb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic b0, obo, oov, bd, da;
    logic [W-1:0] od;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], b0, lat, od, obo, oov, bd, da);
      total++;
      if (b0 !== 1'b1 || lat != W || bd !== 1'b0 || da !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_timing: got busy0=%b latency=%0d busy_at_done=%b done_next=%b, want 1 %0d 0 0",
                 i, b0, lat, bd, da, W);
      end
      total++;
      if (od !== ed[i] || obo !== eb[i] || oov !== eo[i]) begin
        bad++;
        $display("FAIL vec%0d_result: got diff=%h bo=%b ovf=%b, want diff=%h bo=%b ovf=%b",
                 i, od, obo, oov, ed[i], eb[i], eo[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int first = -1;
    logic [W-1:0] d_first = '0;
    @(negedge clk);
    ta = 8'h35; tb = 8'h12; start = 1'b1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      start = (n == 2);
      if (n == 2) begin ta = 8'hFF; tb = 8'h00; end
      else begin ta = W'($urandom); tb = W'($urandom); end
      if (done) begin
        ndone++;
        if (first < 0) begin first = n; d_first = diff; end
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 1 || first != W || d_first !== 8'h23) begin
      bad++;
      $display("FAIL ignore_start: got dones=%0d at=%0d diff=%h, want 1 at %0d diff=23",
               ndone, first, d_first, W);
    end
  endtask

  task automatic test_async_reset();
    int ndone = 0;
    logic b0, obo, oov, bd, da;
    logic [W-1:0] od;
    int lat;
    @(negedge clk);
    ta = 8'h35; tb = 8'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, diff, borrow_out, ovf} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0",
               busy, done, diff, borrow_out, ovf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++;
    if (ndone != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b, want 0 0", ndone, busy);
    end
    run_op(8'h05, 8'h03, b0, lat, od, obo, oov, bd, da);
    total++;
    if (od !== 8'h02 || obo !== 1'b0 || oov !== 1'b0 || lat != W) begin
      bad++;
      $display("FAIL after_reset_op: got diff=%h bo=%b ovf=%b latency=%0d, want 02 0 0 %0d",
               od, obo, oov, lat, W);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    int bad_busy = 0;
    int bad_diff = 0;
    @(negedge clk);
    ta = 8'h09; tb = 8'h04; start = 1'b1;
    for (int n = 0; n < 4 * (W + 1); n++) begin
      @(negedge clk);
      if (busy !== ~done) bad_busy++;
      if (done) begin
        dones.push_back(n);
        if (diff !== 8'h05) bad_diff++;
      end
    end
    start = 1'b0;
    total++;
    if (dones.size() != 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d dones, want 4", dones.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dones[i] != W + i * (W + 1)) begin
          bad++;
          $display("FAIL b2b_spacing%0d: got cycle %0d, want %0d", i, dones[i], W + i * (W + 1));
        end
      end
    end
    total++;
    if (bad_busy != 0 || bad_diff != 0) begin
      bad++;
      $display("FAIL b2b_busy_diff: got %0d busy errors %0d diff errors, want 0 0", bad_busy, bad_diff);
    end
    repeat (W + 2) @(negedge clk);
  endtask

  task automatic test_random();
    logic b0, obo, oov, bd, da;
    logic [W-1:0] od, x, y;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom);
      if (i % 8 == 0) y = x;
      run_op(x, y, b0, lat, od, obo, oov, bd, da);
      total++;
      if (od !== m_diff(x, y) || obo !== m_borrow(x, y) || oov !== m_ovf(x, y) || lat != W) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h: got diff=%h bo=%b ovf=%b lat=%0d, want %h %b %b %0d",
                 i, x, y, od, obo, oov, lat, m_diff(x, y), m_borrow(x, y), m_ovf(x, y), W);
      end
      repeat (3) @(negedge clk);
      total++;
      if (diff !== od || borrow_out !== obo || ovf !== oov) begin
        bad++;
        $display("FAIL rand%0d_hold: got diff=%h bo=%b ovf=%b, want %h %b %b",
                 i, diff, borrow_out, ovf, od, obo, oov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
